// File: rtl/lif_layer_scheduler_pkg.sv
// Shared definitions for the time-multiplexed LIF layer: width defaults,
// scheduler state encoding and the saturating adder used by the update unit.
package snn_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TREF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // a + b clipped to the largest value representable in 'width' bits
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned width);
    int unsigned lim;
    int unsigned s;
    lim = (32'd1 << width) - 32'd1;
    s   = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/lif_layer_scheduler_update.sv
// Combinational LIF neuron update: refractory hold, weighted integration with
// saturation, floored leak, threshold compare.
module lif_update_unit
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TREF_WIDTH = DEF_TREF_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]            pot,
  input  logic [TREF_WIDTH-1:0]            refcnt,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] weights,
  input  logic [NUM_INPUTS-1:0]            spikes,
  input  logic [DATA_WIDTH-1:0]            thr,
  input  logic [DATA_WIDTH-1:0]            leak,
  input  logic [TREF_WIDTH-1:0]            tref,
  output logic [DATA_WIDTH-1:0]            pot_next,
  output logic [TREF_WIDTH-1:0]            ref_next,
  output logic                             spike
);

  localparam int SUM_W = DATA_WIDTH + $clog2(NUM_INPUTS) + 1;

  logic [SUM_W-1:0]      wsum;
  logic [DATA_WIDTH-1:0] sat;
  logic [DATA_WIDTH-1:0] leaked;

  always_comb begin
    wsum = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (spikes[j]) wsum = wsum + SUM_W'(weights[DATA_WIDTH*j +: DATA_WIDTH]);
    end
    sat    = DATA_WIDTH'(sat_add(32'(pot), 32'(wsum), DATA_WIDTH));
    leaked = (sat >= leak) ? sat - leak : '0;

    pot_next = leaked;
    ref_next = '0;
    spike    = 1'b0;
    if (refcnt != '0) begin
      pot_next = '0;
      ref_next = refcnt - 1'b1;
    end else if (leaked >= thr) begin
      pot_next = '0;
      ref_next = tref;
      spike    = 1'b1;
    end
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed LIF layer: one shared update unit walks neurons 0..N-1 per
// step (read, then write back) and publishes the full spike vector at the end.
module lif_layer_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int NUM_INPUTS  = 8,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TREF_WIDTH  = DEF_TREF_WIDTH,
  localparam int IDX_W      = $clog2(NUM_NEURONS),
  // one value wider than the index range so an out-of-range neuron is encodable
  localparam int ADDR_W     = $clog2(NUM_NEURONS + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             step_start,
  input  logic [NUM_INPUTS-1:0]            input_spike,
  input  logic [DATA_WIDTH-1:0]            threshold,
  input  logic [DATA_WIDTH-1:0]            leak_value,
  input  logic [TREF_WIDTH-1:0]            tref,
  input  logic                             cfg_we,
  input  logic [ADDR_W-1:0]                cfg_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] cfg_weight,
  output logic                             busy,
  output logic [NUM_NEURONS-1:0]           output_spike,
  output logic                             spike_valid,
  output logic                             step_drop,
  output logic                             cfg_err
);

  localparam int WV_W = NUM_INPUTS * DATA_WIDTH;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_NEURONS);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_INPUTS-1:0]  spk_in_q, spk_in_d;
  logic [DATA_WIDTH-1:0]  thr_q, thr_d, leak_q, leak_d;
  logic [TREF_WIDTH-1:0]  tref_q, tref_d;
  logic [DATA_WIDTH-1:0]  op_pot_q, op_pot_d;
  logic [TREF_WIDTH-1:0]  op_ref_q, op_ref_d;
  logic [WV_W-1:0]        op_w_q, op_w_d;
  logic [NUM_NEURONS-1:0] shadow_q, shadow_d, out_spike_q, out_spike_d;
  logic                   spike_valid_q, spike_valid_d;
  logic                   step_drop_q, step_drop_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   nrn_we, cfg_ok;

  logic [DATA_WIDTH-1:0]  upd_pot;
  logic [TREF_WIDTH-1:0]  upd_ref;
  logic                   upd_spike;

  logic [DATA_WIDTH-1:0]  pot_arr [NUM_NEURONS];
  logic [TREF_WIDTH-1:0]  ref_arr [NUM_NEURONS];
  logic [WV_W-1:0]        w_arr   [NUM_NEURONS];

  lif_update_unit #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .TREF_WIDTH (TREF_WIDTH)
  ) u_update (
    .pot      (op_pot_q),
    .refcnt   (op_ref_q),
    .weights  (op_w_q),
    .spikes   (spk_in_q),
    .thr      (thr_q),
    .leak     (leak_q),
    .tref     (tref_q),
    .pot_next (upd_pot),
    .ref_next (upd_ref),
    .spike    (upd_spike)
  );

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_nrn
    logic [DATA_WIDTH-1:0] pot_q, pot_d;
    logic [TREF_WIDTH-1:0] ref_q, ref_d;
    logic [WV_W-1:0]       w_q, w_d;

    always_comb begin
      pot_d = pot_q;
      ref_d = ref_q;
      w_d   = w_q;
      if (nrn_we && idx_q == IDX_W'(gi)) begin
        pot_d = upd_pot;
        ref_d = upd_ref;
      end
      if (cfg_ok && cfg_addr == ADDR_W'(gi)) w_d = cfg_weight;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pot_q <= '0;
        ref_q <= '0;
        w_q   <= '0;
      end else begin
        pot_q <= pot_d;
        ref_q <= ref_d;
        w_q   <= w_d;
      end
    end

    assign pot_arr[gi] = pot_q;
    assign ref_arr[gi] = ref_q;
    assign w_arr[gi]   = w_q;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spk_in_d      = spk_in_q;
    thr_d         = thr_q;
    leak_d        = leak_q;
    tref_d        = tref_q;
    op_pot_d      = op_pot_q;
    op_ref_d      = op_ref_q;
    op_w_d        = op_w_q;
    shadow_d      = shadow_q;
    out_spike_d   = out_spike_q;
    spike_valid_d = 1'b0;
    step_drop_d   = 1'b0;
    cfg_err_d     = 1'b0;
    nrn_we        = 1'b0;
    cfg_ok        = 1'b0;

    // weight writes land at the same edge a step is accepted, so READ sees them
    if (cfg_we) begin
      if (state_q == IDLE && cfg_addr < ADDR_LIM) cfg_ok = 1'b1;
      else                                         cfg_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (step_start) begin
          spk_in_d = input_spike;
          thr_d    = threshold;
          leak_d   = leak_value;
          tref_d   = tref;
          idx_d    = '0;
          state_d  = READ;
        end
      end
      READ: begin
        op_pot_d = pot_arr[idx_q];
        op_ref_d = ref_arr[idx_q];
        op_w_d   = w_arr[idx_q];
        state_d  = UPDATE;
      end
      UPDATE: begin
        nrn_we           = 1'b1;
        shadow_d[idx_q]  = upd_spike;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      DONE: begin
        out_spike_d   = shadow_q;
        spike_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (step_start && state_q != IDLE) step_drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      spk_in_q      <= '0;
      thr_q         <= '0;
      leak_q        <= '0;
      tref_q        <= '0;
      op_pot_q      <= '0;
      op_ref_q      <= '0;
      op_w_q        <= '0;
      shadow_q      <= '0;
      out_spike_q   <= '0;
      spike_valid_q <= 1'b0;
      step_drop_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spk_in_q      <= spk_in_d;
      thr_q         <= thr_d;
      leak_q        <= leak_d;
      tref_q        <= tref_d;
      op_pot_q      <= op_pot_d;
      op_ref_q      <= op_ref_d;
      op_w_q        <= op_w_d;
      shadow_q      <= shadow_d;
      out_spike_q   <= out_spike_d;
      spike_valid_q <= spike_valid_d;
      step_drop_q   <= step_drop_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign output_spike = out_spike_q;
  assign spike_valid  = spike_valid_q;
  assign step_drop    = step_drop_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Scoreboard bench for lif_layer_scheduler: a driver pushes model results per
// step, a monitor compares them when spike_valid pulses.
module tb_lif_layer_scheduler;

  localparam int N  = 8;
  localparam int NI = 8;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int AW = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             step_start = 1'b0;
  logic [NI-1:0]    input_spike = '0;
  logic [DW-1:0]    threshold = '0;
  logic [DW-1:0]    leak_value = '0;
  logic [TW-1:0]    tref = '0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [NI*DW-1:0] cfg_weight = '0;
  logic             busy, spike_valid, step_drop, cfg_err;
  logic [N-1:0]     output_spike;

  lif_layer_scheduler #(
    .NUM_NEURONS (N),
    .NUM_INPUTS  (NI),
    .DATA_WIDTH  (DW),
    .TREF_WIDTH  (TW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .step_start   (step_start),
    .input_spike  (input_spike),
    .threshold    (threshold),
    .leak_value   (leak_value),
    .tref         (tref),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_weight   (cfg_weight),
    .busy         (busy),
    .output_spike (output_spike),
    .spike_valid  (spike_valid),
    .step_drop    (step_drop),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [N-1:0]    spk;
    logic [N*DW-1:0] pot;
    logic [N*TW-1:0] rf;
    logic [31:0]     start;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0, exp_drop = 0;
  int err_cnt = 0, exp_err = 0;
  int in_step = 0;

  // behavioural layer state
  int m_pot [N];
  int m_ref [N];
  int m_w   [N][NI];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_pot[n] = 0;
      m_ref[n] = 0;
      for (int j = 0; j < NI; j++) m_w[n][j] = 0;
    end
  endtask

  task automatic model_step(input logic [NI-1:0] inp, input int thr, input int leak,
                            input int tr, output logic [N-1:0] spk);
    int s;
    spk = '0;
    for (int n = 0; n < N; n++) begin
      if (m_ref[n] > 0) begin
        m_ref[n]--;
        m_pot[n] = 0;
      end else begin
        s = m_pot[n];
        for (int j = 0; j < NI; j++) if (inp[j]) s += m_w[n][j];
        if (s > 255) s = 255;
        s = (s >= leak) ? s - leak : 0;
        if (s >= thr) begin
          spk[n]   = 1'b1;
          m_pot[n] = 0;
          m_ref[n] = tr;
        end else begin
          m_pot[n] = s;
        end
      end
    end
  endtask

  function automatic logic [NI*DW-1:0] wv_all(input int b);
    logic [NI*DW-1:0] v;
    for (int j = 0; j < NI; j++) v[DW*j +: DW] = DW'(b);
    return v;
  endfunction

  // drive a weight write without advancing time; model decides accept/reject
  task automatic set_cfg(input int addr, input logic [NI*DW-1:0] wv);
    cfg_we     = 1'b1;
    cfg_addr   = AW'(addr);
    cfg_weight = wv;
    if (in_step == 0 && addr < N) begin
      for (int j = 0; j < NI; j++) m_w[addr][j] = int'(wv[DW*j +: DW]);
    end else begin
      exp_err++;
    end
  endtask

  task automatic cfg_write(input int addr, input logic [NI*DW-1:0] wv);
    set_cfg(addr, wv);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic issue_step(input logic [NI-1:0] inp, input int thr, input int leak, input int tr);
    exp_t e;
    logic [N-1:0] spk;
    input_spike = inp;
    threshold   = DW'(thr);
    leak_value  = DW'(leak);
    tref        = TW'(tr);
    step_start  = 1'b1;
    model_step(inp, thr, leak, tr, spk);
    e.spk   = spk;
    for (int i = 0; i < N; i++) begin
      e.pot[DW*i +: DW] = DW'(m_pot[i]);
      e.rf[TW*i +: TW]  = TW'(m_ref[i]);
    end
    e.start = 32'(cyc + 1);
    sb_q.push_back(e);
    in_step = 1;
    @(negedge clk);
    step_start = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!spike_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("step_complete", int'(spike_valid), 1);
    in_step = 0;
  endtask

  task automatic run_step(input logic [NI-1:0] inp, input int thr, input int leak, input int tr);
    issue_step(inp, thr, leak, tr);
    wait_done();
  endtask

  // monitor: pulse counters and scoreboard comparison on spike_valid
  always @(negedge clk) begin
    exp_t e;
    if (step_drop) drop_cnt++;
    if (cfg_err)   err_cnt++;
    if (spike_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_spike_valid", int'(spike_valid), 0);
      end else begin
        e = sb_q.pop_front();
        check("output_spike", int'(output_spike), int'(e.spk));
        check("latency", cyc - int'(e.start), 17);
        for (int i = 0; i < N; i++) begin
          check($sformatf("pot[%0d]", i), int'(dut.pot_arr[i]), int'(e.pot[DW*i +: DW]));
          check($sformatf("refcnt[%0d]", i), int'(dut.ref_arr[i]), int'(e.rf[TW*i +: TW]));
        end
        $display("step done t=%0t out=%02h", $time, output_spike);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_output_spike", int'(output_spike), 0);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_step_drop", int'(step_drop), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1 integrate/fire
    for (int n = 0; n < N; n++) cfg_write(n, wv_all(1));
    run_step(8'hFF, 21, 1, 2);
    check("t1_pot0_step1", int'(dut.pot_arr[0]), 7);
    run_step(8'hFF, 21, 1, 2);
    check("t1_pot0_step2", int'(dut.pot_arr[0]), 14);
    run_step(8'hFF, 21, 1, 2);
    check("t1_out_step3", int'(output_spike), 8'hFF);

    // T2 refractory
    run_step(8'hFF, 21, 1, 2);
    check("t2_out_step4", int'(output_spike), 0);
    run_step(8'hFF, 21, 1, 2);
    check("t2_out_step5", int'(output_spike), 0);
    check("t2_pot0_step5", int'(dut.pot_arr[0]), 0);
    run_step(8'hFF, 21, 1, 2);
    check("t2_pot0_step6", int'(dut.pot_arr[0]), 7);

    // T3a saturation
    cfg_write(0, wv_all(8'hFF));
    run_step(8'hFF, 255, 1, 2);
    check("t3_pot0_sat", int'(dut.pot_arr[0]), 254);
    check("t3_no_spike0", int'(output_spike[0]), 0);

    // T4 step_start while busy at +3 and +10
    issue_step(8'hFF, 255, 1, 2);
    repeat (2) @(negedge clk);
    step_start = 1'b1; exp_drop++;
    @(negedge clk);
    step_start = 1'b0;
    repeat (6) @(negedge clk);
    step_start = 1'b1; exp_drop++;
    @(negedge clk);
    step_start = 1'b0;
    wait_done();
    @(negedge clk);
    check("t4_step_drop_count", drop_cnt, exp_drop);

    // T5 rejected weight writes
    issue_step(8'h0F, 100, 2, 1);
    repeat (3) @(negedge clk);
    cfg_write(2, wv_all(8'h55));
    wait_done();
    cfg_write(8, wv_all(8'h33));
    @(negedge clk);
    check("t5_cfg_err_count", err_cnt, exp_err);
    run_step(8'hFF, 100, 2, 1);

    // weight write and step_start together: step uses the new weights
    set_cfg(3, wv_all(8'h20));
    run_step(8'hFF, 200, 0, 1);

    // T6 reset mid-step
    issue_step(8'hFF, 50, 1, 1);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    sb_q.delete();
    model_reset();
    in_step = 0;
    @(negedge clk);
    check("t6_busy", int'(busy), 0);
    check("t6_output_spike", int'(output_spike), 0);
    for (int i = 0; i < N; i++) check($sformatf("t6_pot[%0d]", i), int'(dut.pot_arr[i]), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // T3b leak floor on zero weights, then threshold 0 fires everyone
    run_step(8'hFF, 200, 5, 1);
    check("t3_leak_floor_pot0", int'(dut.pot_arr[0]), 0);
    run_step(8'hFF, 0, 5, 1);
    check("thr0_all_fire", int'(output_spike), 8'hFF);

    // randomized steps against the model
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < 3; c++) begin
        logic [NI*DW-1:0] wv;
        for (int j = 0; j < NI; j++) wv[DW*j +: DW] = DW'($urandom_range(0, 40));
        cfg_write(int'($urandom_range(0, N)), wv);
      end
      run_step(NI'($urandom), (it % 4 == 3) ? 0 : int'($urandom_range(10, 120)),
               int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    check("final_step_drop_count", drop_cnt, exp_drop);
    check("final_cfg_err_count", err_cnt, exp_err);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
